// File: rtl/fifo_wm_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wm_pkg
// Shared definitions for the watermark FIFO.
//   occ_op_t    : the occupancy update applied on a clock edge. It is encoded
//                 as {pop, push} so that the controller can build it directly
//                 from its two enable terms.
//   count_width : the width of the occupancy counter. The counter must be able
//                 to hold 0..DEPTH, so it needs one bit more than a pointer.
// ---------------------------------------------------------------------------
package fifo_wm_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } occ_op_t;

    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_wm_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wm_ctrl
// Holds the FIFO read and write pointers, the occupancy count and every
// status flag. All of these are registers, so none of the flags can glitch
// within a cycle.
//
// Optional feature: when FIFO_WATERMARK_ERR_EN is defined, the controller
// also provides sticky overflow and underflow flags and a clr_err input.
//
// Ports
//   clk, reset     : clock; asynchronous active-high reset
//   rd, wr         : pop and push requests
//   clr_err        : clears the sticky error flags (FIFO_WATERMARK_ERR_EN only)
//   overflow       : sticky flag, write attempted while full (ERR_EN only)
//   underflow      : sticky flag, read attempted while empty (ERR_EN only)
//   write_en       : tells the storage array to store w_data at w_addr
//   w_addr, r_addr : storage pointers; they wrap naturally at DEPTH
//   count          : occupancy, 0..DEPTH
//   empty, full, almost_empty, almost_full : registered status flags
// ---------------------------------------------------------------------------
module fifo_wm_ctrl
    import fifo_wm_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rd,
    input  logic                                wr,
`ifdef FIFO_WATERMARK_ERR_EN
    input  logic                                clr_err,
    output logic                                overflow,
    output logic                                underflow,
`endif
    output logic                                write_en,
    output logic [ADDR_WIDTH-1:0]               w_addr,
    output logic [ADDR_WIDTH-1:0]               r_addr,
    output logic [count_width(ADDR_WIDTH)-1:0]  count,
    output logic                                empty,
    output logic                                full,
    output logic                                almost_empty,
    output logic                                almost_full
);

    localparam int CW    = count_width(ADDR_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic          push_en;
    logic          pop_en;
    occ_op_t       op;
    logic [CW-1:0] count_next;

    // A push is allowed while full only when a pop happens on the same edge.
    // The head slot is freed on that edge, so the new word can take its place.
    assign pop_en   = rd & ~empty;
    assign push_en  = wr & (~full | rd);
    assign write_en = push_en;
    assign op       = occ_op_t'({pop_en, push_en});

    // Next occupancy. A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count;
        case (op)
            OP_PUSH: count_next = count + CW'(1);
            OP_POP:  count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // The pointers, the count and the flags all update on the same edge.
    // Each flag is computed from count_next, so it is registered together
    // with the count and always agrees with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_addr       <= '0;
            r_addr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            if (push_en) begin
                w_addr <= w_addr + 1'b1;
            end
            if (pop_en) begin
                r_addr <= r_addr + 1'b1;
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == CW'(DEPTH));
            almost_empty <= (count_next <= CW'(AE_LEVEL));
            almost_full  <= (count_next >= CW'(AF_LEVEL));
        end
    end

`ifdef FIFO_WATERMARK_ERR_EN
    // Sticky error flags. A set event takes priority over clr_err in the
    // same cycle, so an error that occurs while clearing is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr & full & ~rd) | (overflow & ~clr_err);
            underflow <= (rd & empty) | (underflow & ~clr_err);
        end
    end
`endif

endmodule

// File: rtl/fifo_watermark.sv
// ---------------------------------------------------------------------------
// fifo_watermark
// A single-clock FIFO with almost_empty and almost_full watermark flags.
// This file holds the storage array and the combinational read mux, so the
// head word appears on r_data as soon as r_addr settles. The fifo_wm_ctrl
// submodule holds the pointers, the count and the flags. Storage is not
// reset; the reset only clears the pointers, which discards any queued data.
//
// Optional feature: macro FIFO_WATERMARK_ERR_EN adds the ports overflow,
// underflow and clr_err.
//
// Ports
//   clk, reset       : clock; asynchronous active-high reset
//   rd, wr           : pop and push requests
//   w_data           : data for a push
//   r_data           : word at the head (don't-care while empty)
//   empty, full      : occupancy is 0, occupancy is DEPTH
//   almost_empty     : count <= AE_LEVEL
//   almost_full      : count >= AF_LEVEL
//   count            : occupancy, 0..DEPTH
//   clr_err, overflow, underflow : sticky error interface (ERR_EN only)
// ---------------------------------------------------------------------------
module fifo_watermark
    import fifo_wm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd,
    input  logic                   wr,
    input  logic [DATA_WIDTH-1:0]  w_data,
    output logic [DATA_WIDTH-1:0]  r_data,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
`ifdef FIFO_WATERMARK_ERR_EN
    input  logic                   clr_err,
    output logic                   overflow,
    output logic                   underflow,
`endif
    output logic [ADDR_WIDTH:0]    count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Stop elaboration if a watermark threshold is outside its legal range.
    generate
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("fifo_watermark: AF_LEVEL must be within 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
            $error("fifo_watermark: AE_LEVEL must be within 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  write_en;

    fifo_wm_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .AF_LEVEL   (AF_LEVEL),
        .AE_LEVEL   (AE_LEVEL)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .rd           (rd),
        .wr           (wr),
`ifdef FIFO_WATERMARK_ERR_EN
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .write_en     (write_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full)
    );

    // Storage has no reset so that it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[w_addr] <= w_data;
        end
    end

    // The read is combinational, so the head word follows r_addr directly.
    assign r_data = mem[r_addr];

endmodule

// File: tb/tb_fifo_watermark.sv
// ---------------------------------------------------------------------------
// tb_fifo_watermark
// Directed and random stimulus for fifo_watermark. The reference model is a
// queue of words: pushes and pops follow the FIFO's occupancy rules, and the
// flags are derived from the queue size. Define FIFO_WATERMARK_ERR_EN to
// also exercise the sticky error ports.
// ---------------------------------------------------------------------------
module tb_fifo_watermark;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd;
    logic          wr;
    logic [DW-1:0] w_data;
    logic [DW-1:0] r_data;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [AW:0]   count;
`ifdef FIFO_WATERMARK_ERR_EN
    logic          clr_err;
    logic          overflow;
    logic          underflow;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [DW-1:0] model_q[$];
    bit            m_ovf;
    bit            m_unf;

    always #5 clk = ~clk;

    fifo_watermark #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd           (rd),
        .wr           (wr),
        .w_data       (w_data),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
`ifdef FIFO_WATERMARK_ERR_EN
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .count        (count)
    );

    // Compares one observed value with its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares every DUT output with the model's view of the queue.
    task automatic checkOutput(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".count"}, 32'(count), 32'(sz));
        check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        check({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= AF));
        if (sz > 0) begin
            check({tag, ".r_data"}, 32'(r_data), 32'(model_q[0]));
        end
`ifdef FIFO_WATERMARK_ERR_EN
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
`endif
    endtask

    // Drives one clock cycle of requests and applies the same operation to
    // the model. Outputs can be checked when this task returns, #1 after the
    // rising edge.
    task automatic applyStimulus(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
        int sz;
        bit do_pop;
        bit do_push;
        bit set_o;
        bit set_u;
        @(negedge clk);
        wr     = w;
        rd     = r;
        w_data = d;
`ifdef FIFO_WATERMARK_ERR_EN
        clr_err = c;
`endif
        @(posedge clk);
        sz      = model_q.size();
        do_pop  = r && (sz > 0);
        do_push = w && ((sz < DEPTH) || do_pop);
        set_o   = w && (sz == DEPTH) && !r;
        set_u   = r && (sz == 0);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        if (set_o) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (set_u) m_unf = 1'b1; else if (c) m_unf = 1'b0;
        #1;
    endtask

    initial begin
        $display("[TB] start");
        reset  = 1'b1;
        rd     = 1'b0;
        wr     = 1'b0;
        w_data = '0;
`ifdef FIFO_WATERMARK_ERR_EN
        clr_err = 1'b0;
`endif
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b0;

        // Fill the FIFO: watch the count and the watermarks step, with the head fixed at 0x11.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
            checkOutput("fill");
        end

        // A write while full is discarded.
        applyStimulus(1'b1, 1'b0, 8'hEE, 1'b0);
        checkOutput("wr_full");

        // Drain it. The pointers wrap back to 0.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
            checkOutput("drain");
        end

        // A read while empty changes nothing.
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("rd_empty");

        // Simultaneous push and pop while full.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
        checkOutput("refill");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0);
            checkOutput("both_full");
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
            checkOutput("drain_aa");
        end

        // Simultaneous push and pop while empty: only the push happens.
        applyStimulus(1'b1, 1'b1, 8'h5C, 1'b0);
        checkOutput("both_empty");

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        checkOutput("pre_reset");
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        #2;
        reset = 1'b1;
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        checkOutput("async_reset");
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h77, 1'b0);
        checkOutput("post_reset");

`ifdef FIFO_WATERMARK_ERR_EN
        // Sticky error flags.
        while (model_q.size() > 0) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hF0, 1'b0);
        checkOutput("ovf_set");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("ovf_hold");
        applyStimulus(1'b1, 1'b0, 8'hF1, 1'b1);
        checkOutput("ovf_set_wins");
        while (model_q.size() > 0) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("unf_set");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("err_clr");
`endif

        // Random traffic. Each phase uses a different push/pop bias so the
        // FIFO is driven to both extremes.
        for (int phase = 0; phase < 4; phase++) begin
            int wr_pct;
            int rd_pct;
            wr_pct = (phase % 2 == 0) ? 75 : 25;
            rd_pct = (phase % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 100; i++) begin
                bit w;
                bit r;
                bit c;
                w = ($urandom_range(0, 99) < 32'(wr_pct));
                r = ($urandom_range(0, 99) < 32'(rd_pct));
                c = ($urandom_range(0, 19) == 0);
                applyStimulus(w, r, 8'($urandom), c);
                checkOutput("random");
            end
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fifo_watermark.md
FIFO_WATERMARK -- requirements
Module: fifo_watermark

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per word.
REQ-002 Parameter ADDR_WIDTH, default 3: address bits; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter AF_LEVEL, default 6: almost_full threshold in words, range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 1: almost_empty threshold in words, range 0..DEPTH-1.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 rd  in  1  pop request.
REQ-008 wr  in  1  push request.
REQ-009 w_data  in  DATA_WIDTH  push data.
REQ-010 r_data  out  DATA_WIDTH  head word; combinational from storage at the read pointer.
REQ-011 empty, full  out  1 each  occupancy == 0 and occupancy == DEPTH respectively.
REQ-012 almost_empty, almost_full  out  1 each  count <= AE_LEVEL and count >= AF_LEVEL respectively.
REQ-013 count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Function
REQ-014 Pointers w_addr and r_addr shall be ADDR_WIDTH bits and shall wrap from DEPTH-1 to 0 without special handling.
REQ-015 A push (wr & ~full) shall write w_data at w_addr and increment w_addr on the same edge.
REQ-016 A pop (rd & ~empty) shall increment r_addr; r_data shall show the next word in the same cycle the pointer settles (zero-latency head).
REQ-017 wr & rd when empty: push only; rd ignored; count +1.
REQ-018 wr & rd when full: both pop and push occur; count unchanged; full remains 1.
REQ-019 wr & rd otherwise: both occur; count unchanged.
REQ-020 wr when full without rd: write discarded, no state change; rd when empty: no state change.
REQ-021 count, empty, full, almost_empty and almost_full shall be registered, updated on the same edge as the pointers, never derived from a comparison that glitches within a cycle.
REQ-022 r_data content while empty is don't-care; the bench shall not check it.

Reset
REQ-023 Assertion of reset shall immediately force w_addr=0, r_addr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, independent of clk.
REQ-024 Storage contents shall not be reset; reset mid-operation discards all queued words.
REQ-025 Operation shall resume on the first rising edge after deassertion.

Configuration
REQ-026 Macro FIFO_WATERMARK_ERR_EN defined: ports overflow (out 1), underflow (out 1) and clr_err (in 1) exist; overflow sets sticky on wr & full & ~rd; underflow sets sticky on rd & empty; both clear on clr_err or reset; a set event in the same cycle as clr_err wins.
REQ-027 Macro undefined: those three ports and their logic are absent; all other behaviour is identical.

Structure
REQ-028 Package fifo_wm_pkg shall hold the occupancy-update encoding (enum of NOP/PUSH/POP/BOTH) and a function computing the count width from ADDR_WIDTH.
REQ-029 One sub-module, fifo_wm_ctrl, shall hold pointers, count and all flags; the storage array and read mux stay in fifo_watermark.
REQ-030 Elaboration shall fail if AF_LEVEL or AE_LEVEL is outside its range.

Verification (defaults: DEPTH 8, AF 6, AE 1)
REQ-031 Reset, then push 0x11..0x18 -> count steps 1..8; almost_empty drops after the 2nd push; almost_full rises after the 6th; full after the 8th; r_data=0x11 throughout.
REQ-032 From full, pop 8 -> r_data sequence 0x11..0x18; count 8..0; empty=1 after the last pop; pointers have wrapped to 0.
REQ-033 Full FIFO, wr=rd=1 with w_data 0xAA for 3 cycles -> count stays 8, full stays 1; subsequent 8 pops return 0x14..0x18, 0xAA, 0xAA, 0xAA.
REQ-034 Empty FIFO, wr=rd=1 with w_data 0x5C -> count=1, empty=0, r_data=0x5C.
REQ-035 Push 3, assert reset between edges -> count, empty, and flags change before the next clk edge; push 0x77 afterward -> r_data=0x77.
REQ-036 With FIFO_WATERMARK_ERR_EN: push to full then wr alone -> overflow=1 and held; pop from empty -> underflow=1; clr_err for 1 cycle -> both 0.
